soc_axi_sram_slave: RTL and testbench

//  AXI4 slave terminating the NoC crossbar's single master port (ID width NOC_S_ID_WIDTH) in an on-chip SRAM.

---
 rtl/soc_axi_sram_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_soc_axi_sram_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_axi_sram_slave.sv
// AXI4 slave that serialises one read or write burst at a time onto a
// single-port SRAM with one-cycle read latency.
package soc_pkg;
  localparam int NOC_S_ID_WIDTH = 6;
  localparam int NOC_USER_WIDTH = 4;

  typedef struct packed {
    logic [NOC_S_ID_WIDTH-1:0] id;
    logic [63:0]               addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [5:0]                atop;
    logic [NOC_USER_WIDTH-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [NOC_S_ID_WIDTH-1:0] id;
    logic [63:0]               addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [NOC_USER_WIDTH-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0]               data;
    logic [7:0]                strb;
    logic                      last;
    logic [NOC_USER_WIDTH-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [NOC_S_ID_WIDTH-1:0] id;
    logic [1:0]                resp;
    logic [NOC_USER_WIDTH-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [NOC_S_ID_WIDTH-1:0] id;
    logic [63:0]               data;
    logic [1:0]                resp;
    logic                      last;
    logic [NOC_USER_WIDTH-1:0] user;
  } r_chan_t;

  typedef struct packed {
    logic     aw_valid;
    aw_chan_t aw;
    logic     w_valid;
    w_chan_t  w;
    logic     b_ready;
    logic     ar_valid;
    ar_chan_t ar;
    logic     r_ready;
  } s_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } s_resp_t;
endpackage

module soc_axi_sram_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MEM_BYTES = 65536,
  parameter type         req_t     = soc_pkg::s_req_t,
  parameter type         resp_t    = soc_pkg::s_resp_t,
  localparam int unsigned MEM_AW   = $clog2(MEM_BYTES / 8)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  req_t              axi_req_i,
  output resp_t             axi_resp_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_be_o,
  input  logic [63:0]       mem_rdata_i
);
  localparam int unsigned OFF_MSB     = $clog2(MEM_BYTES) - 1;
  localparam logic        PRIO_WRITE  = 1'b0;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RD_REQ, RD_RESP} state_e;

  state_e                            state_reg;
  logic                              rr_prio_reg;
  logic [soc_pkg::NOC_S_ID_WIDTH-1:0] id_reg;
  logic [63:0]                       addr_reg;
  logic [7:0]                        len_reg;
  logic [7:0]                        beat_reg;
  logic [2:0]                        size_reg;
  logic [1:0]                        burst_reg;
  logic                              err_reg;
  logic                              rd_first_reg;
  logic [63:0]                       rdata_reg;

  logic        grant_w, grant_r, both_valid, beat_err, last_beat, unused_req;
  logic [63:0] offset, next_addr, rd_data;

  assign unused_req = ^axi_req_i;
  assign both_valid = axi_req_i.aw_valid && axi_req_i.ar_valid;
  assign grant_w    = !rst_i && (state_reg == IDLE) && axi_req_i.aw_valid &&
                      (!axi_req_i.ar_valid || (rr_prio_reg == PRIO_WRITE));
  assign grant_r    = !rst_i && (state_reg == IDLE) && axi_req_i.ar_valid && !grant_w;

  // An address below BASE_ADDR wraps the offset far above MEM_BYTES, so one compare covers both ends.
  assign offset     = addr_reg - BASE_ADDR;
  assign beat_err   = (offset >= 64'(MEM_BYTES)) || (size_reg > 3'd3);
  assign last_beat  = (beat_reg == len_reg);
  assign next_addr  = (burst_reg == BURST_FIXED) ? addr_reg : addr_reg + (64'd1 << size_reg);
  assign rd_data    = beat_err ? 64'd0 : mem_rdata_i;

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = grant_w;
    axi_resp_o.ar_ready = grant_r;
    axi_resp_o.w_ready  = (state_reg == WRITE);
    if (state_reg == WRESP) begin
      axi_resp_o.b_valid = 1'b1;
      axi_resp_o.b.id    = id_reg;
      axi_resp_o.b.resp  = err_reg ? RESP_SLVERR : RESP_OKAY;
    end
    if (state_reg == RD_RESP) begin
      axi_resp_o.r_valid = 1'b1;
      axi_resp_o.r.id    = id_reg;
      // SRAM output is only valid on the first response cycle; later cycles replay the capture.
      axi_resp_o.r.data  = rd_first_reg ? rd_data : rdata_reg;
      axi_resp_o.r.resp  = beat_err ? RESP_SLVERR : RESP_OKAY;
      axi_resp_o.r.last  = last_beat;
    end
    mem_req_o   = !rst_i && !beat_err &&
                  (((state_reg == WRITE) && axi_req_i.w_valid) || (state_reg == RD_REQ));
    mem_we_o    = (state_reg == WRITE);
    mem_addr_o  = offset[OFF_MSB:3];
    mem_wdata_o = axi_req_i.w.data;
    mem_be_o    = axi_req_i.w.strb;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      rr_prio_reg  <= PRIO_WRITE;
      id_reg       <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_reg     <= '0;
      size_reg     <= '0;
      burst_reg    <= '0;
      err_reg      <= 1'b0;
      rd_first_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_w) begin
            id_reg    <= axi_req_i.aw.id;
            addr_reg  <= axi_req_i.aw.addr;
            len_reg   <= axi_req_i.aw.len;
            size_reg  <= axi_req_i.aw.size;
            burst_reg <= axi_req_i.aw.burst;
            beat_reg  <= '0;
            err_reg   <= 1'b0;
            state_reg <= WRITE;
          end else if (grant_r) begin
            id_reg    <= axi_req_i.ar.id;
            addr_reg  <= axi_req_i.ar.addr;
            len_reg   <= axi_req_i.ar.len;
            size_reg  <= axi_req_i.ar.size;
            burst_reg <= axi_req_i.ar.burst;
            beat_reg  <= '0;
            state_reg <= RD_REQ;
          end
          if (both_valid) rr_prio_reg <= ~rr_prio_reg;
        end
        WRITE: begin
          if (axi_req_i.w_valid) begin
            if (beat_err || (axi_req_i.w.last != last_beat)) err_reg <= 1'b1;
            addr_reg <= next_addr;
            beat_reg <= beat_reg + 8'd1;
            if (last_beat) state_reg <= WRESP;
          end
        end
        WRESP: begin
          if (axi_req_i.b_ready) state_reg <= IDLE;
        end
        RD_REQ: begin
          rd_first_reg <= 1'b1;
          state_reg    <= RD_RESP;
        end
        RD_RESP: begin
          rd_first_reg <= 1'b0;
          if (rd_first_reg) rdata_reg <= rd_data;
          if (axi_req_i.r_ready) begin
            addr_reg  <= next_addr;
            beat_reg  <= beat_reg + 8'd1;
            state_reg <= last_beat ? IDLE : RD_REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_axi_sram_slave.sv
// Directed bench for soc_axi_sram_slave: single-beat vector table plus burst,
// arbitration, backpressure and reset sequences against a behavioural SRAM.
`timescale 1ns/1ps
module tb_soc_axi_sram_slave;
  import soc_pkg::*;

  localparam int         TIMEOUT = 50;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;
  localparam logic [1:0] INCR    = 2'b01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  s_req_t      req;
  s_resp_t     resp;
  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic [63:0] sram [0:8191];
  int          tests = 0;
  int          fails = 0;
  int          strobes = 0;

  always #5 clk = ~clk;

  soc_axi_sram_slave dut (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(resp),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  // Read data is only defined the cycle after a read strobe; otherwise it is garbage.
  always @(posedge clk) begin
    if (mem_req) strobes <= strobes + 1;
    if (mem_req && mem_we)
      for (int b = 0; b < 8; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= (mem_req && !mem_we) ? sram[mem_addr] : {$urandom, $urandom};
  end

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [5:0]  id;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
    int          exp_strobes;
  } vec_t;

  vec_t        vecs [9];
  logic [63:0] incr_exp [4];
  logic [63:0] bp_data [8];
  bit          bp_pat [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic aw_chan_t mk_aw(input logic [5:0] id, input logic [63:0] addr,
                                     input logic [7:0] len, input logic [2:0] size);
    aw_chan_t a;
    a = '0; a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = INCR;
    return a;
  endfunction

  function automatic ar_chan_t mk_ar(input logic [5:0] id, input logic [63:0] addr,
                                     input logic [7:0] len, input logic [2:0] size);
    ar_chan_t a;
    a = '0; a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = INCR;
    return a;
  endfunction

  // All handshake tasks start and end just after a falling edge.
  task automatic aw_send(input aw_chan_t a);
    int n = 0;
    req.aw = a; req.aw_valid = 1'b1; #1;
    while (!resp.aw_ready && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("aw_handshake", 64'(resp.aw_ready), 64'd1);
    @(negedge clk); req.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input ar_chan_t a);
    int n = 0;
    req.ar = a; req.ar_valid = 1'b1; #1;
    while (!resp.ar_ready && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("ar_handshake", 64'(resp.ar_ready), 64'd1);
    @(negedge clk); req.ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    req.w = '0; req.w.data = d; req.w.strb = s; req.w.last = l; req.w_valid = 1'b1; #1;
    while (!resp.w_ready && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("w_handshake", 64'(resp.w_ready), 64'd1);
    @(negedge clk); req.w_valid = 1'b0;
  endtask

  task automatic b_recv(output logic [5:0] id, output logic [1:0] r);
    int n = 0;
    req.b_ready = 1'b1; #1;
    while (!resp.b_valid && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("b_handshake", 64'(resp.b_valid), 64'd1);
    id = resp.b.id; r = resp.b.resp;
    @(negedge clk); req.b_ready = 1'b0;
  endtask

  task automatic r_recv(output logic [63:0] d, output logic [1:0] r, output logic l, output logic [5:0] id);
    int n = 0;
    req.r_ready = 1'b1; #1;
    while (!resp.r_valid && n < TIMEOUT) begin @(negedge clk); #1; n++; end
    check("r_handshake", 64'(resp.r_valid), 64'd1);
    d = resp.r.data; r = resp.r.resp; l = resp.r.last; id = resp.r.id;
    @(negedge clk); req.r_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata, held;
    logic        rlast;
    int          s0, beats, k;
    bit          stalled;

    vecs[0] = '{1'b1, 64'h100,   3'd3, 6'h2A, 64'hDEADBEEF_CAFEF00D, 8'hFF, OKAY,   64'h0, 1};
    vecs[1] = '{1'b0, 64'h100,   3'd3, 6'h15, 64'h0, 8'h00, OKAY,   64'hDEADBEEF_CAFEF00D, 1};
    vecs[2] = '{1'b1, 64'h10000, 3'd3, 6'h03, 64'h1234, 8'hFF, SLVERR, 64'h0, 0};
    vecs[3] = '{1'b0, 64'h10000, 3'd3, 6'h04, 64'h0, 8'h00, SLVERR, 64'h0, 0};
    vecs[4] = '{1'b1, 64'hFFF8,  3'd3, 6'h05, 64'h1111_2222_3333_4444, 8'hFF, OKAY, 64'h0, 1};
    vecs[5] = '{1'b1, 64'hFFF8,  3'd3, 6'h06, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, OKAY, 64'h0, 1};
    vecs[6] = '{1'b0, 64'hFFF8,  3'd3, 6'h07, 64'h0, 8'h00, OKAY,   64'hAAAA_BBBB_3333_4444, 1};
    vecs[7] = '{1'b0, 64'h104,   3'd3, 6'h3F, 64'h0, 8'h00, OKAY,   64'hDEADBEEF_CAFEF00D, 1};
    vecs[8] = '{1'b0, 64'h100,   3'd4, 6'h08, 64'h0, 8'h00, SLVERR, 64'h0, 0};
    incr_exp = '{64'h1, 64'h2, 64'h5555_6666_0000_0003, 64'h4};
    for (int i = 0; i < 8; i++) bp_data[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0001;
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    check("reset_resp_zero", 64'(resp == '0), 64'd1);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      s0 = strobes;
      if (vecs[i].wr) begin
        aw_send(mk_aw(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size));
        w_send(vecs[i].wdata, vecs[i].strb, 1'b1);
        b_recv(bid, bresp);
        check($sformatf("v%0d_bid", i), 64'(bid), 64'(vecs[i].id));
        check($sformatf("v%0d_bresp", i), 64'(bresp), 64'(vecs[i].exp_resp));
      end else begin
        ar_send(mk_ar(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size));
        r_recv(rdata, rresp, rlast, rid);
        check($sformatf("v%0d_rid", i), 64'(rid), 64'(vecs[i].id));
        check($sformatf("v%0d_rresp", i), 64'(rresp), 64'(vecs[i].exp_resp));
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        check($sformatf("v%0d_rlast", i), 64'(rlast), 64'd1);
      end
      check($sformatf("v%0d_strobes", i), 64'(strobes - s0), 64'(vecs[i].exp_strobes));
    end

    // INCR write with a partial strobe on beat 2 over a known old word.
    aw_send(mk_aw(6'h01, 64'h210, 8'd0, 3'd3));
    w_send(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    aw_send(mk_aw(6'h09, 64'h200, 8'd3, 3'd3));
    for (int i = 0; i < 4; i++) w_send(64'(i + 1), (i == 2) ? 8'h0F : 8'hFF, i == 3);
    b_recv(bid, bresp);
    check("incr_bid", 64'(bid), 64'h09);
    check("incr_bresp", 64'(bresp), 64'(OKAY));
    ar_send(mk_ar(6'h0A, 64'h200, 8'd3, 3'd3));
    for (int i = 0; i < 4; i++) begin
      r_recv(rdata, rresp, rlast, rid);
      check($sformatf("incr_rdata%0d", i), rdata, incr_exp[i]);
      check($sformatf("incr_rlast%0d", i), 64'(rlast), 64'(i == 3));
    end

    // W.last asserted early: burst still runs len+1 beats, B reports SLVERR.
    aw_send(mk_aw(6'h0B, 64'h700, 8'd1, 3'd3));
    w_send(64'h1, 8'hFF, 1'b1);
    w_send(64'h2, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    check("wlast_bresp", 64'(bresp), 64'(SLVERR));

    // Read len=7 under 1-0-0-1 r_ready pattern.
    aw_send(mk_aw(6'h0C, 64'h400, 8'd7, 3'd3));
    for (int i = 0; i < 8; i++) w_send(bp_data[i], 8'hFF, i == 7);
    b_recv(bid, bresp);
    ar_send(mk_ar(6'h0D, 64'h400, 8'd7, 3'd3));
    beats = 0; k = 0; stalled = 1'b0; held = '0;
    while (beats < 8 && k < 200) begin
      req.r_ready = bp_pat[k % 4]; #1;
      if (resp.r_valid) begin
        if (stalled) check($sformatf("bp_stable%0d", beats), resp.r.data, held);
        if (req.r_ready) begin
          check($sformatf("bp_rdata%0d", beats), resp.r.data, bp_data[beats]);
          check($sformatf("bp_rlast%0d", beats), 64'(resp.r.last), 64'(beats == 7));
          beats++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = resp.r.data;
        end
      end
      @(negedge clk); k++;
    end
    req.r_ready = 1'b0;
    check("bp_beats", 64'(beats), 64'd8);

    // Reset in the middle of a len=3 write.
    aw_send(mk_aw(6'h11, 64'h600, 8'd3, 3'd3));
    w_send(64'h1, 8'hFF, 1'b0);
    w_send(64'h2, 8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    check("rst_resp_zero", 64'(resp == '0), 64'd1);
    check("rst_w_ready", 64'(resp.w_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    aw_send(mk_aw(6'h22, 64'h608, 8'd0, 3'd3));
    w_send(64'h99, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    check("rst_next_bid", 64'(bid), 64'h22);
    check("rst_next_bresp", 64'(bresp), 64'(OKAY));

    // Arbitration: write priority after reset, then read priority.
    req.aw = mk_aw(6'h31, 64'h800, 8'd0, 3'd3); req.ar = mk_ar(6'h32, 64'h100, 8'd0, 3'd3);
    req.aw_valid = 1'b1; req.ar_valid = 1'b1; #1;
    check("arb1_aw_ready", 64'(resp.aw_ready), 64'd1);
    check("arb1_ar_ready", 64'(resp.ar_ready), 64'd0);
    @(negedge clk); req.aw_valid = 1'b0;
    w_send(64'h77, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    check("arb1_bid", 64'(bid), 64'h31);
    ar_send(mk_ar(6'h32, 64'h100, 8'd0, 3'd3));
    r_recv(rdata, rresp, rlast, rid);
    check("arb1_rid", 64'(rid), 64'h32);
    check("arb1_rdata", rdata, 64'hDEADBEEF_CAFEF00D);

    req.aw = mk_aw(6'h34, 64'h808, 8'd0, 3'd3); req.ar = mk_ar(6'h33, 64'h800, 8'd0, 3'd3);
    req.aw_valid = 1'b1; req.ar_valid = 1'b1; #1;
    check("arb2_ar_ready", 64'(resp.ar_ready), 64'd1);
    check("arb2_aw_ready", 64'(resp.aw_ready), 64'd0);
    @(negedge clk); req.ar_valid = 1'b0;
    r_recv(rdata, rresp, rlast, rid);
    check("arb2_rid", 64'(rid), 64'h33);
    check("arb2_rdata", rdata, 64'h77);
    aw_send(mk_aw(6'h34, 64'h808, 8'd0, 3'd3));
    w_send(64'h88, 8'hFF, 1'b1);
    b_recv(bid, bresp);
    check("arb2_bid", 64'(bid), 64'h34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
